// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte-serial load/store initiator for the MEM stage.
// Forms ea = address + exmem_rs, range-checks it against the attached memory,
// then runs four big-endian byte beats while holding the pipeline in stall.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 101
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] address,
    input  logic [4:0]  exmem_rs,
    input  logic [31:0] writedata,
    output logic        stall,
    output logic [31:0] readdata,
    output logic        rd_valid,
    output logic        addr_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BEAT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // Highest legal byte address, widened so the range check never wraps.
    localparam logic [32:0] LAST_ADDR = 33'(MEM_BYTES - 1);

    logic [1:0]  state_reg, state_next;
    logic [1:0]  b_reg, b_next;
    logic [31:0] ea_reg, ea_next;
    logic [31:0] wdata_reg, wdata_next;
    logic        store_reg, store_next;
    logic        err_reg, err_next;
    logic [31:0] asm_reg, asm_next;
    logic [31:0] readdata_reg, readdata_next;

    logic        req_any;
    logic [32:0] ea_calc;
    logic        range_bad;
    logic        in_beat;
    logic [7:0]  wbyte [4];
    logic [31:0] asm_merged;

    assign req_any   = memread | memwrite;
    assign ea_calc   = {1'b0, address} + {28'b0, exmem_rs};
    assign range_bad = (ea_calc + 33'd3) > LAST_ADDR;
    assign in_beat   = (state_reg == BEAT);

    // Byte lanes, big-endian: lane 0 is the MSB byte at the lowest address.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign wbyte[gi] = wdata_reg[31 - 8*gi -: 8];
            assign asm_merged[31 - 8*gi -: 8] =
                (b_reg == 2'(gi)) ? mem_rdata : asm_reg[31 - 8*gi -: 8];
        end
    endgenerate

    // Next-state and datapath update for the access sequencer.
    always_comb begin
        state_next    = state_reg;
        b_next        = b_reg;
        ea_next       = ea_reg;
        wdata_next    = wdata_reg;
        store_next    = store_reg;
        err_next      = err_reg;
        asm_next      = asm_reg;
        readdata_next = readdata_reg;
        case (state_reg)
            IDLE: begin
                if (req_any) begin
                    // A store wins when both requests are raised together.
                    store_next = memwrite;
                    wdata_next = writedata;
                    ea_next    = ea_calc[31:0];
                    b_next     = 2'd0;
                    if (range_bad) begin
                        err_next   = 1'b1;
                        state_next = DONE;
                        if (!memwrite) begin
                            readdata_next = 32'h0;
                        end
                    end else begin
                        err_next   = 1'b0;
                        state_next = BEAT;
                    end
                end
            end
            BEAT: begin
                if (mem_ready) begin
                    if (!store_reg) begin
                        asm_next = asm_merged;
                    end
                    b_next = b_reg + 2'd1;
                    if (b_reg == 2'd3) begin
                        state_next = DONE;
                        if (!store_reg) begin
                            readdata_next = asm_merged;
                        end
                    end
                end
            end
            DONE: begin
                // Requests seen here belong to the instruction being released.
                state_next = IDLE;
                err_next   = 1'b0;
            end
            default: state_next = IDLE;
        endcase
    end

    // State registers with asynchronous reset so an access aborts at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            b_reg        <= 2'd0;
            ea_reg       <= 32'h0;
            wdata_reg    <= 32'h0;
            store_reg    <= 1'b0;
            err_reg      <= 1'b0;
            asm_reg      <= 32'h0;
            readdata_reg <= 32'h0;
        end else begin
            state_reg    <= state_next;
            b_reg        <= b_next;
            ea_reg       <= ea_next;
            wdata_reg    <= wdata_next;
            store_reg    <= store_next;
            err_reg      <= err_next;
            asm_reg      <= asm_next;
            readdata_reg <= readdata_next;
        end
    end

    // Stall rises combinationally on a new request so EX/MEM freezes at once;
    // gated by rst_n so reset forces it low even with a request pending.
    assign stall     = rst_n & (((state_reg == IDLE) & req_any) | in_beat);
    assign mem_req   = in_beat;
    assign mem_we    = in_beat & store_reg;
    assign mem_addr  = in_beat ? (ea_reg + {30'b0, b_reg}) : 32'h0;
    assign mem_wdata = in_beat ? wbyte[b_reg] : 8'h00;
    assign rd_valid  = (state_reg == DONE) & ~store_reg;
    assign addr_err  = (state_reg == DONE) & err_reg;
    assign readdata  = readdata_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl. Stimulus pushes
// expected beats and load/error responses; a negedge monitor pops and compares.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        memread = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] address = 32'h0;
    logic [4:0]  exmem_rs = 5'h0;
    logic [31:0] writedata = 32'h0;
    logic        stall;
    logic [31:0] readdata;
    logic        rd_valid;
    logic        addr_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ready;

    always #5 clk = ~clk;

    mem_access_ctrl #(.MEM_BYTES(101)) dut (
        .clk(clk), .rst_n(rst_n), .memread(memread), .memwrite(memwrite),
        .address(address), .exmem_rs(exmem_rs), .writedata(writedata),
        .stall(stall), .readdata(readdata), .rd_valid(rd_valid),
        .addr_err(addr_err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [7:0]  wdata;
    } beat_t;

    typedef struct {
        logic        rv;
        logic        err;
        logic [31:0] data;
    } resp_t;

    beat_t beat_q[$];
    resp_t resp_q[$];

    int          n_checks = 0;
    int          n_errs = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_rd = 32'h0;

    // Responder memory: byte i initialised to i; optional wait states on one address.
    logic [7:0]  mem_model [0:100];
    logic [31:0] hold_addr = 32'hFFFF_FFFF;
    int          hold_left = 0;

    assign mem_ready = !(mem_req && (mem_addr == hold_addr) && (hold_left > 0));
    assign mem_rdata = (mem_addr < 32'd101) ? mem_model[mem_addr[6:0]] : 8'h00;

    always @(posedge clk) begin
        if (mem_req && mem_ready && mem_we && (mem_addr < 32'd101))
            mem_model[mem_addr[6:0]] <= mem_wdata;
        if (mem_req && !mem_ready)
            hold_left <= hold_left - 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: compare every beat (held beats peeked, completed beats popped)
    // and every rd_valid/addr_err pulse against the scoreboard queues.
    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_req) begin
                if (beat_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL beat_unexpected: got addr %h with no beat expected", mem_addr);
                end else begin
                    check("beat_addr", mem_addr, beat_q[0].addr);
                    check("beat_we", {31'b0, mem_we}, {31'b0, beat_q[0].we});
                    if (beat_q[0].we)
                        check("beat_wdata", {24'b0, mem_wdata}, {24'b0, beat_q[0].wdata});
                    if (mem_ready)
                        void'(beat_q.pop_front());
                end
            end
            if (rd_valid || addr_err) begin
                if (resp_q.size() == 0) begin
                    n_checks++;
                    n_errs++;
                    $display("FAIL resp_unexpected: got rd_valid=%0b addr_err=%0b with none expected",
                             rd_valid, addr_err);
                end else begin
                    check("resp_rd_valid", {31'b0, rd_valid}, {31'b0, resp_q[0].rv});
                    check("resp_addr_err", {31'b0, addr_err}, {31'b0, resp_q[0].err});
                    check("resp_readdata", readdata, resp_q[0].data);
                    void'(resp_q.pop_front());
                end
            end
        end
    end

    // Issue one request, push its expectations, hold it through DONE, then drop it.
    task automatic access(input string name, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [4:0] rs,
                          input logic [31:0] wd, input logic [31:0] exp_word,
                          input int exp_stall);
        logic [32:0] ea;
        logic        err;
        int          cnt;
        bit          done;
        ea  = {1'b0, addr} + {28'b0, rs};
        err = (ea + 33'd3) > 33'd100;
        if (err) begin
            if (!wr) last_rd = 32'h0;
            resp_q.push_back('{rv: !wr, err: 1'b1, data: last_rd});
        end else begin
            for (int i = 0; i < 4; i++)
                beat_q.push_back('{addr: ea[31:0] + 32'(i), we: wr, wdata: wd[31 - 8*i -: 8]});
            if (!wr) begin
                last_rd = exp_word;
                resp_q.push_back('{rv: 1'b1, err: 1'b0, data: exp_word});
            end
        end
        memread   = rd;
        memwrite  = wr;
        address   = addr;
        exmem_rs  = rs;
        writedata = wd;
        cnt  = 0;
        done = 1'b0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) cnt++;
            else done = 1'b1;
        end
        if (!done) begin
            n_checks++;
            n_errs++;
            $display("FAIL %s_timeout: stall still high after 40 cycles, required release", name);
        end
        check({name, "_stall_cycles"}, 32'(cnt), 32'(exp_stall));
        if (wr && !err)
            check({name, "_readdata_kept"}, readdata, last_rd);
        $display("txn %s ea=%0h rd=%0b wr=%0b stall_cycles=%0d readdata=%h",
                 name, ea, rd, wr, cnt, readdata);
        @(posedge clk);
        #1;
        memread  = 1'b0;
        memwrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required $finish");
        $fatal(1);
    end

    initial begin
        bit seen;
        for (int i = 0; i < 101; i++) mem_model[i] = 8'(i);

        // Reset with a request pending: everything must read zero.
        memread = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_stall", {31'b0, stall}, 32'h0);
        check("rst_readdata", readdata, 32'h0);
        check("rst_pulses", {30'b0, rd_valid, addr_err}, 32'h0);
        check("rst_mem_req", {30'b0, mem_req, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wdata", {24'b0, mem_wdata}, 32'h0);
        memread = 1'b0;
        rst_n   = 1'b1;
        mon_en  = 1'b1;
        idle(1);

        access("load_ea12", 1'b1, 1'b0, 32'd8, 5'd4, 32'h0, 32'h0C0D0E0F, 5);
        idle(1);
        access("store_ea20", 1'b0, 1'b1, 32'd16, 5'd4, 32'hDEADBEEF, 32'h0, 5);
        idle(1);
        access("load_ea20", 1'b1, 1'b0, 32'd20, 5'd0, 32'h0, 32'hDEADBEEF, 5);
        idle(1);

        hold_addr = 32'd17;
        hold_left = 2;
        access("load_wait_ea16", 1'b1, 1'b0, 32'd16, 5'd0, 32'h0, 32'h10111213, 7);
        idle(1);

        access("load_ea97", 1'b1, 1'b0, 32'd90, 5'd7, 32'h0, 32'h61626364, 5);
        idle(1);
        access("load_err_ea98", 1'b1, 1'b0, 32'd96, 5'd2, 32'h0, 32'h0, 1);
        idle(1);
        access("store_err_wrap", 1'b0, 1'b1, 32'hFFFF_FFFF, 5'd1, 32'h12345678, 32'h0, 1);
        idle(1);

        access("both_store_ea40", 1'b1, 1'b1, 32'd40, 5'd0, 32'hA5A55A5A, 32'h0, 5);
        idle(1);
        access("load_ea40", 1'b1, 1'b0, 32'd40, 5'd0, 32'h0, 32'hA5A55A5A, 5);
        idle(1);

        // Back-to-back: the load's request stays up through DONE, store follows at once.
        access("b2b_load_ea12", 1'b1, 1'b0, 32'd12, 5'd0, 32'h0, 32'h0C0D0E0F, 5);
        access("b2b_store_ea30", 1'b0, 1'b1, 32'd30, 5'd0, 32'h11223344, 32'h0, 5);
        idle(1);
        access("load_ea30", 1'b1, 1'b0, 32'd30, 5'd0, 32'h0, 32'h11223344, 5);
        idle(1);

        // Reset during beat 2 of a store.
        mon_en    = 1'b0;
        memwrite  = 1'b1;
        address   = 32'd50;
        exmem_rs  = 5'd0;
        writedata = 32'hCAFEF00D;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (mem_req && mem_addr == 32'd52) seen = 1'b1;
        end
        check("rst_mid_reached_beat2", {31'b0, seen}, 32'h1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_stall", {31'b0, stall}, 32'h0);
        check("rst_mid_mem_req", {30'b0, mem_req, mem_we}, 32'h0);
        check("rst_mid_mem_addr", mem_addr, 32'h0);
        check("rst_mid_mem_wdata", {24'b0, mem_wdata}, 32'h0);
        check("rst_mid_readdata", readdata, 32'h0);
        memwrite = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        beat_q.delete();
        resp_q.delete();
        last_rd = 32'h0;
        idle(1);
        mon_en = 1'b1;
        access("load_after_rst", 1'b1, 1'b0, 32'd8, 5'd4, 32'h0, 32'h0C0D0E0F, 5);
        idle(3);

        check("beat_q_drained", 32'(beat_q.size()), 32'h0);
        check("resp_q_drained", 32'(resp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
